// File: rtl/count_seq_ctrl.sv
// Sequencer for an external enable/sync-reset up-counter: one-shot or auto-reload runs to a limit, with pause/abort.
// Optional prescaler on counter steps is compiled in with COUNT_SEQ_PRESCALE_EN.
module count_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int RUNS_WIDTH = 8
`ifdef COUNT_SEQ_PRESCALE_EN
  , parameter int PRESC_WIDTH = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic                  cfg_reload,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRESC_WIDTH-1:0] cfg_presc,
`endif
  input  logic [WIDTH-1:0]      count_i,
  output logic                  cnt_en,
  output logic                  cnt_rst,
  output logic                  busy,
  output logic                  done,
  output logic [RUNS_WIDTH-1:0] run_count
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lim_q;
  logic             reload_q;
  logic             at_limit;
  logic             accept;
  logic             period_end;
  logic             step_ok;

  assign at_limit   = (count_i == lim_q);
  assign accept     = (state == IDLE) && start;
  assign period_end = (state == RUN) && !stop && at_limit;
  assign busy       = (state != IDLE);

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] presc_cnt;

  assign step_ok = (presc_cnt == presc_q);

  // Prescaler advances only in RUN, holds in HOLD, and restarts from 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      presc_cnt <= '0;
    end else begin
      if (accept) presc_q <= cfg_presc;
      if (state == RUN) presc_cnt <= step_ok ? '0 : presc_cnt + 1'b1;
      else if (state != HOLD) presc_cnt <= '0;
    end
  end
`else
  assign step_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_rst   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_rst   = 1'b1;
        state_nxt = stop ? IDLE : RUN;
      end
      RUN: begin
        cnt_en = !at_limit && step_ok && !stop;
        if (stop)          state_nxt = IDLE;
        else if (at_limit) state_nxt = reload_q ? CLEAR : IDLE;
        else if (pause)    state_nxt = HOLD;
      end
      HOLD: begin
        if (stop)        state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset holds the counter cleared regardless of the registered state.
    if (rst) begin
      cnt_en  = 1'b0;
      cnt_rst = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lim_q     <= '0;
      reload_q  <= 1'b0;
      done      <= 1'b0;
      run_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= period_end;
      if (accept) begin
        lim_q     <= cfg_limit;
        reload_q  <= cfg_reload;
        run_count <= '0;
      end else if (period_end && (run_count != '1)) begin
        run_count <= run_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a behavioural model of the controlled counter.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, cfg_reload;
  logic [7:0] cfg_limit;
  logic [7:0] cnt;
  logic       cnt_en, cnt_rst, busy, done;
  logic [7:0] run_count;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [3:0] cfg_presc;
`endif

  int checks = 0;
  int errors = 0;
  int e, en_cnt, done_cnt, done_at;

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(8), .RUNS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .cfg_limit(cfg_limit), .cfg_reload(cfg_reload),
`ifdef COUNT_SEQ_PRESCALE_EN
    .cfg_presc(cfg_presc),
`endif
    .count_i(cnt), .cnt_en(cnt_en), .cnt_rst(cnt_rst), .busy(busy),
    .done(done), .run_count(run_count)
  );

  // The counter being sequenced.
  always_ff @(posedge clk) begin
    if (cnt_rst)     cnt <= '0;
    else if (cnt_en) cnt <= cnt + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    e++;
    if (done)   begin done_cnt++; done_at = e; end
    if (cnt_en) en_cnt++;
  endtask

  // Pulse start for one edge; afterwards e=0 means "just after the start edge".
  task automatic go(input logic [7:0] lim, input logic rl);
    cfg_limit  = lim;
    cfg_reload = rl;
    start      = 1'b1;
    cyc();
    start    = 1'b0;
    e        = 0;
    en_cnt   = 0;
    done_cnt = 0;
    done_at  = -1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    cfg_limit = '0; cfg_reload = 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
    cfg_presc = '0;
`endif
    e = 0; en_cnt = 0; done_cnt = 0; done_at = -1;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_runs", run_count, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_cntrst", cnt_rst, 1);
    rst = 1'b0;
    #1;
    chk("idle_cntrst", cnt_rst, 0);

    // One-shot, limit 5; a later cfg change must not matter.
    go(8'd5, 1'b0);
    cfg_limit = 8'd9;
    chk("os_clear", cnt_rst, 1);
    chk("os_busy", busy, 1);
    repeat (10) cyc();
    chk("os_en_cycles", en_cnt, 5);
    chk("os_done_cnt", done_cnt, 1);
    chk("os_done_at", done_at, 7);
    chk("os_count", cnt, 5);
    chk("os_busy_end", busy, 0);
    chk("os_runs", run_count, 1);

    // Auto-reload, limit 3: period 5.
    go(8'd3, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk($sformatf("ar_count_%0d", i), cnt, (i % 5 == 0) ? 3 : (i % 5) - 1);
    end
    chk("ar_done_cnt", done_cnt, 4);
    chk("ar_done_at", done_at, 20);
    chk("ar_runs", run_count, 4);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("ar_stop_busy", busy, 0);
    chk("ar_stop_runs", run_count, 4);
    chk("ar_stop_done", done, 0);

    // Pause for 6 edges, raised while count is 3 so the counter holds at 4.
    go(8'd10, 1'b0);
    repeat (4) cyc();
    pause = 1'b1;
    cyc();
    chk("pz_count_a", cnt, 4);
    chk("pz_en_a", cnt_en, 0);
    repeat (3) cyc();
    chk("pz_count_b", cnt, 4);
    chk("pz_busy", busy, 1);
    repeat (2) cyc();
    pause = 1'b0;
    repeat (10) cyc();
    chk("pz_done_at", done_at, 18);
    chk("pz_done_cnt", done_cnt, 1);
    chk("pz_count_end", cnt, 10);

    // Stop at count 7 with a simultaneous start.
    go(8'd20, 1'b0);
    repeat (8) cyc();
    chk("st_count_pre", cnt, 7);
    chk("st_en_pre", cnt_en, 1);
    stop = 1'b1; start = 1'b1;
    #1;
    chk("st_en_gate", cnt_en, 0);
    cyc();
    stop = 1'b0; start = 1'b0;
    chk("st_busy", busy, 0);
    repeat (3) cyc();
    chk("st_busy_later", busy, 0);
    chk("st_count_held", cnt, 7);
    chk("st_no_done", done_cnt, 0);
    chk("st_runs", run_count, 0);

    // Limit 0: immediate terminal match.
    go(8'd0, 1'b0);
    repeat (5) cyc();
    chk("l0_done_at", done_at, 2);
    chk("l0_en", en_cnt, 0);
    chk("l0_done_cnt", done_cnt, 1);
    chk("l0_runs", run_count, 1);

    // Limit all-ones, one-shot.
    go(8'd255, 1'b0);
    repeat (260) cyc();
    chk("lmax_done_at", done_at, 257);
    chk("lmax_en", en_cnt, 255);
    chk("lmax_count", cnt, 255);
    chk("lmax_runs", run_count, 1);

    // run_count saturation: 300 periods of length 2.
    go(8'd0, 1'b1);
    repeat (600) cyc();
    chk("sat_done_cnt", done_cnt, 300);
    chk("sat_runs", run_count, 255);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("sat_stop_runs", run_count, 255);

`ifdef COUNT_SEQ_PRESCALE_EN
    cfg_presc = 4'd2;
    go(8'd4, 1'b0);
    cfg_presc = 4'd0;
    repeat (16) cyc();
    chk("ps_done_at", done_at, 14);
    chk("ps_en", en_cnt, 4);
`endif

    // Reset in the middle of a run.
    go(8'd10, 1'b1);
    repeat (5) cyc();
    rst = 1'b1;
    #1;
    chk("mr_cntrst_now", cnt_rst, 1);
    chk("mr_en_now", cnt_en, 0);
    cyc();
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_runs", run_count, 0);
    chk("mr_en", cnt_en, 0);
    chk("mr_cntrst", cnt_rst, 1);
    rst = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
